// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard/redirect controller: stall vector, branch and exception redirect
// Optional stall-cycle performance counter enabled by defining PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        exc_flag,
  input  logic [31:0] exc_vector,
  output logic [5:0]  stall,
  output logic        flush_id,
  output logic        flush_all,
  output logic        new_pc_valid,
  output logic [31:0] new_pc,
  output logic        busy
`ifdef PIPE_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    EXC_FLUSH = 2'b01,
    REFILL    = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] vec_q, vec_d;

  logic [5:0]  stall_req;
  logic [5:0]  stall_c;
  logic        flush_id_c, flush_all_c, new_pc_valid_c, busy_c;
  logic [31:0] new_pc_c;

  always_comb begin
    if (stallreq_mem)      stall_req = 6'b011111;
    else if (stallreq_ex)  stall_req = 6'b001111;
    else if (stallreq_id)  stall_req = 6'b000111;
    else if (stallreq_if)  stall_req = 6'b000011;
    else                   stall_req = 6'b000000;
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pend_d         = pend_q;
    tgt_d          = tgt_q;
    vec_d          = vec_q;
    stall_c        = stall_req;
    flush_id_c     = 1'b0;
    flush_all_c    = 1'b0;
    new_pc_valid_c = 1'b0;
    new_pc_c       = 32'h0;
    busy_c         = (state_q != RUN) || pend_q;

    case (state_q)
      RUN: begin
        // A pending branch yields to an exception in the same cycle; a fresh branch does not.
        if (pend_q) begin
          if (!stall_req[2] && !exc_flag) begin
            flush_id_c     = 1'b1;
            new_pc_valid_c = 1'b1;
            new_pc_c       = tgt_q;
            pend_d         = 1'b0;
          end
        end else if (branch_flag) begin
          if (!stall_req[2]) begin
            flush_id_c     = 1'b1;
            new_pc_valid_c = 1'b1;
            new_pc_c       = branch_target;
          end else begin
            pend_d = 1'b1;
            tgt_d  = branch_target;
            busy_c = 1'b1;
          end
        end
        if (exc_flag) begin
          vec_d   = exc_vector;
          pend_d  = 1'b0;
          state_d = EXC_FLUSH;
        end
      end
      EXC_FLUSH: begin
        stall_c        = 6'b000000;
        flush_all_c    = 1'b1;
        new_pc_valid_c = 1'b1;
        new_pc_c       = vec_q;
        cnt_d          = 2'd2;
        state_d        = REFILL;
      end
      REFILL: begin
        // Refill only progresses while the front end is actually advancing.
        if (!stall_req[1]) begin
          if (cnt_q <= 2'd1) begin
            cnt_d   = 2'd0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
      pend_q  <= 1'b0;
      tgt_q   <= 32'h0;
      vec_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
      vec_q   <= vec_d;
    end
  end

  assign stall        = rst ? stall_c        : 6'b000000;
  assign flush_id     = rst & flush_id_c;
  assign flush_all    = rst & flush_all_c;
  assign new_pc_valid = rst & new_pc_valid_c;
  assign new_pc       = rst ? new_pc_c       : 32'h0;
  assign busy         = rst & busy_c;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall[0]) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) stall_cycles_q <= 32'h0;
    else      stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = rst ? stall_cycles_q : 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        exc_flag;
  logic [31:0] exc_vector;
  logic [5:0]  stall;
  logic        flush_id, flush_all, new_pc_valid, busy;
  logic [31:0] new_pc;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .exc_flag(exc_flag), .exc_vector(exc_vector),
    .stall(stall), .flush_id(flush_id), .flush_all(flush_all),
    .new_pc_valid(new_pc_valid), .new_pc(new_pc), .busy(busy)
`ifdef PIPE_CTRL_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  task automatic clear_inputs();
    stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    branch_flag = 0; branch_target = 32'h0; exc_flag = 0; exc_vector = 32'h0;
  endtask

  task automatic test_reset();
    rst = 0;
    @(negedge clk);
    stallreq_mem = 1; branch_flag = 1; branch_target = 32'h1234; exc_flag = 1; exc_vector = 32'h88;
    #1;
    n_chk++; if (stall !== 6'b0) begin n_fail++; $display("FAIL rst_stall got %b want 000000", stall); end
    n_chk++; if (new_pc_valid !== 1'b0 || new_pc !== 32'h0) begin n_fail++; $display("FAIL rst_newpc got %b/%h want 0/0", new_pc_valid, new_pc); end
    n_chk++; if (flush_id !== 1'b0 || flush_all !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_flags got %b%b%b want 000", flush_id, flush_all, busy); end
    @(negedge clk);
    clear_inputs(); rst = 1;
    #1;
    n_chk++; if (busy !== 1'b0 || stall !== 6'b0) begin n_fail++; $display("FAIL rst_release got busy=%b stall=%b want 0/000000", busy, stall); end
  endtask

  task automatic test_stall_priority();
    logic [3:0] req [8];
    logic [5:0] exp [8];
    req[0] = 4'b0000; exp[0] = 6'b000000;
    req[1] = 4'b1000; exp[1] = 6'b000011;
    req[2] = 4'b0100; exp[2] = 6'b000111;
    req[3] = 4'b0010; exp[3] = 6'b001111;
    req[4] = 4'b0001; exp[4] = 6'b011111;
    req[5] = 4'b1111; exp[5] = 6'b011111;
    req[6] = 4'b0101; exp[6] = 6'b011111;
    req[7] = 4'b0100; exp[7] = 6'b000111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = req[i];
      #1;
      n_chk++; if (stall !== exp[i]) begin n_fail++; $display("FAIL stall_prio[%0d] got %b want %b", i, stall, exp[i]); end
    end
    @(negedge clk); clear_inputs();
  endtask

  task automatic test_branch();
    @(negedge clk);
    branch_flag = 1; branch_target = 32'h0040_0020;
    #1;
    n_chk++; if (flush_id !== 1'b1 || new_pc_valid !== 1'b1 || new_pc !== 32'h0040_0020 || flush_all !== 1'b0)
      begin n_fail++; $display("FAIL branch got fid=%b v=%b pc=%h fall=%b want 1/1/00400020/0", flush_id, new_pc_valid, new_pc, flush_all); end
    @(negedge clk); clear_inputs(); #1;
    n_chk++; if (new_pc_valid !== 1'b0 || new_pc !== 32'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL branch_after got v=%b pc=%h busy=%b want 0/0/0", new_pc_valid, new_pc, busy); end
  endtask

  task automatic test_branch_stalled();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      stallreq_ex = 1;
      branch_flag = (c != 2);
      branch_target = (c == 0) ? 32'h0000_1000 : 32'h0000_2000;
      #1;
      n_chk++; if (new_pc_valid !== 1'b0 || flush_id !== 1'b0 || busy !== 1'b1)
        begin n_fail++; $display("FAIL brstall[%0d] got v=%b fid=%b busy=%b want 0/0/1", c, new_pc_valid, flush_id, busy); end
    end
    @(negedge clk); clear_inputs(); #1;
    n_chk++; if (new_pc_valid !== 1'b1 || flush_id !== 1'b1 || new_pc !== 32'h0000_1000 || busy !== 1'b1)
      begin n_fail++; $display("FAIL brstall_issue got v=%b fid=%b pc=%h busy=%b want 1/1/00001000/1", new_pc_valid, flush_id, new_pc, busy); end
    @(negedge clk); #1;
    n_chk++; if (new_pc_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL brstall_done got v=%b busy=%b want 0/0", new_pc_valid, busy); end
  endtask

  task automatic test_exception();
    @(negedge clk); stallreq_ex = 1; branch_flag = 1; branch_target = 32'h0000_3000;
    @(negedge clk); branch_flag = 0; exc_flag = 1; exc_vector = 32'hBFC0_0380; #1;
    n_chk++; if (new_pc_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL exc_entry got v=%b busy=%b want 0/1", new_pc_valid, busy); end
    @(negedge clk); clear_inputs(); stallreq_mem = 1; #1;
    n_chk++; if (flush_all !== 1'b1 || flush_id !== 1'b0 || new_pc_valid !== 1'b1 || new_pc !== 32'hBFC0_0380)
      begin n_fail++; $display("FAIL exc_flush got fall=%b fid=%b v=%b pc=%h want 1/0/1/bfc00380", flush_all, flush_id, new_pc_valid, new_pc); end
    n_chk++; if (stall !== 6'b0) begin n_fail++; $display("FAIL exc_flush_stall got %b want 000000", stall); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); clear_inputs(); branch_flag = 1; branch_target = 32'h0000_4000; #1;
      n_chk++; if (new_pc_valid !== 1'b0 || flush_id !== 1'b0 || flush_all !== 1'b0 || busy !== 1'b1)
        begin n_fail++; $display("FAIL refill[%0d] got v=%b fid=%b fall=%b busy=%b want 0/0/0/1", c, new_pc_valid, flush_id, flush_all, busy); end
    end
    @(negedge clk); clear_inputs(); #1;
    n_chk++; if (busy !== 1'b0 || new_pc_valid !== 1'b0) begin n_fail++; $display("FAIL exc_run got busy=%b v=%b want 0/0", busy, new_pc_valid); end
  endtask

  task automatic test_refill_freeze();
    @(negedge clk); exc_flag = 1; exc_vector = 32'h0000_0180;
    @(negedge clk); clear_inputs();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); clear_inputs(); stallreq_if = (c < 3); #1;
      n_chk++; if (busy !== 1'b1 || stall !== ((c < 3) ? 6'b000011 : 6'b000000))
        begin n_fail++; $display("FAIL refill_freeze[%0d] got busy=%b stall=%b want 1", c, busy, stall); end
    end
    @(negedge clk); clear_inputs(); #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL refill_freeze_end got busy=%b want 0", busy); end
  endtask

  task automatic test_simultaneous();
    @(negedge clk); branch_flag = 1; branch_target = 32'h0000_5000; exc_flag = 1; exc_vector = 32'h0000_6000; #1;
    n_chk++; if (flush_id !== 1'b1 || new_pc_valid !== 1'b1 || new_pc !== 32'h0000_5000)
      begin n_fail++; $display("FAIL simul_branch got fid=%b v=%b pc=%h want 1/1/00005000", flush_id, new_pc_valid, new_pc); end
    @(negedge clk); clear_inputs(); #1;
    n_chk++; if (flush_all !== 1'b1 || new_pc !== 32'h0000_6000) begin n_fail++; $display("FAIL simul_exc got fall=%b pc=%h want 1/00006000", flush_all, new_pc); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk); clear_inputs(); exc_flag = 1; exc_vector = 32'h0000_7000;
    @(negedge clk); clear_inputs(); rst = 0; #1;
    n_chk++; if (flush_all !== 1'b0 || new_pc_valid !== 1'b0 || new_pc !== 32'h0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL rstmid_hold got fall=%b v=%b pc=%h busy=%b want 0", flush_all, new_pc_valid, new_pc, busy); end
    @(negedge clk); rst = 1; #1;
    n_chk++; if (busy !== 1'b0 || flush_all !== 1'b0 || new_pc_valid !== 1'b0 || stall !== 6'b0)
      begin n_fail++; $display("FAIL rstmid_run got busy=%b fall=%b v=%b stall=%b want 0", busy, flush_all, new_pc_valid, stall); end
    @(negedge clk); stallreq_id = 1; branch_flag = 1; branch_target = 32'h0000_8000;
    @(negedge clk); clear_inputs(); rst = 0;
    @(negedge clk); rst = 1; #1;
    n_chk++; if (new_pc_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstpend got v=%b busy=%b want 0/0", new_pc_valid, busy); end
  endtask

`ifdef PIPE_CTRL_PERF_CNT_EN
  task automatic test_perf_cnt();
    @(negedge clk); clear_inputs(); dut.stall_cycles_q = 32'hFFFF_FFFE; stallreq_if = 1;
    repeat (2) @(negedge clk);
    @(negedge clk); clear_inputs(); #1;
    n_chk++; if (stall_cycles !== 32'h0000_0001) begin n_fail++; $display("FAIL perf_wrap got %h want 00000001", stall_cycles); end
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
    test_stall_priority();
    test_branch();
    test_branch_stalled();
    test_exception();
    test_refill_freeze();
    test_simultaneous();
    test_reset_mid();
`ifdef PIPE_CTRL_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock; all state changes on posedge clk.
REQ-002 SHALL have ports: rst  input  1  synchronous active-low reset; sampled only on posedge clk.
REQ-003 SHALL have ports: stallreq_if / stallreq_id / stallreq_ex / stallreq_mem  input  1 each  stall requests from the instruction-fetch wait, load-use detection, multi-cycle EX unit and data-memory wait.
REQ-004 SHALL have ports: branch_flag  input  1  taken branch resolved in ID; branch_target  input  32  its target.
REQ-005 SHALL have ports: exc_flag  input  1  exception raised in MEM; exc_vector  input  32  handler address.
REQ-006 SHALL have ports: stall  output  6  freeze per stage; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
REQ-007 SHALL have ports: flush_id  output  1  clear IF/ID to pc=0, inst=0; flush_all  output  1  clear all pipeline registers.
REQ-008 SHALL have ports: new_pc_valid  output  1  redirect PC this cycle; new_pc  output  32  redirect address.
REQ-009 SHALL have ports: busy  output  1  high when state is not RUN or a branch is pending.

Function
REQ-010 Stall vector SHALL be combinational, with highest stage winning: mem -> 011111, ex -> 001111, id -> 000111, if -> 000011, none -> 000000.
REQ-011 FSM states SHALL be RUN, EXC_FLUSH and REFILL, encoded in 2 bits; the unused encoding SHALL return to RUN on the next edge.
REQ-012 RUN: exc_flag=1 at an edge SHALL latch exc_vector and move to EXC_FLUSH; exc_flag SHALL be honoured even while stalled.
REQ-013 EXC_FLUSH (exactly 1 cycle): flush_all=1, new_pc_valid=1, new_pc=latched vector, stall=000000 regardless of requests; next state REFILL.
REQ-014 REFILL (exactly 2 cycles, 2-bit down-counter): branch_flag SHALL be ignored as wrong-path; stalls act per REQ-010; the counter SHALL freeze while stall[1]=1; at zero, go to RUN.
REQ-015 Branch in RUN with stall[2]=0: same cycle flush_id=1, new_pc_valid=1, new_pc=branch_target.
REQ-016 Branch in RUN with stall[2]=1: latch branch_target into a pending register, with no redirect that cycle.
  - The pending branch SHALL issue per REQ-015 in the first cycle stall[2]=0.
  - A new branch_flag while pending SHALL be ignored.
REQ-017 Priority: exception > pending branch > new branch; an exception SHALL discard any pending branch.
REQ-018 Simultaneous exc_flag and branch_flag in RUN: the branch SHALL still redirect that cycle (REQ-015); the exception takes effect next cycle and overrides it.
REQ-019 new_pc SHALL be 0 whenever new_pc_valid=0; flush_id and flush_all SHALL never both be 1.

Reset
REQ-020 rst=0 at an edge SHALL force state RUN, counter 0, pending branch cleared, latched vector 0.
  - This SHALL hold mid-EXC_FLUSH, mid-REFILL, or with a branch pending.
REQ-021 While rst=0, outputs SHALL be: stall=000000, flush_id=0, flush_all=0, new_pc_valid=0, new_pc=0, busy=0, stall_cycles=0.

Configuration
REQ-022 Macro PIPE_CTRL_PERF_CNT_EN defined: add output stall_cycles (output, 32 bits).
  - stall_cycles SHALL increment by 1 each cycle stall[0]=1 and wrap from FFFFFFFF to 0.
  - It SHALL be cleared only by reset.
REQ-023 Macro PIPE_CTRL_PERF_CNT_EN undefined: the stall_cycles port and its counter SHALL be absent, with all other behaviour identical.

Verification
REQ-024 stallreq_id=1 and stallreq_mem=1 together -> stall=011111; release mem only -> stall=000111.
REQ-025 branch_flag=1, branch_target=0x00400020, no stall -> same cycle flush_id=1, new_pc_valid=1, new_pc=0x00400020.
REQ-026 branch_flag with stallreq_ex=1 for 3 cycles -> no redirect for 3 cycles; redirect to the target in the cycle after the stall drops; busy=1 throughout.
REQ-027 exc_flag=1, exc_vector=0xBFC00380, with a branch pending -> next cycle flush_all=1 and new_pc=0xBFC00380; pending branch never issues; then 2 REFILL cycles where branch_flag is ignored.
REQ-028 rst=0 asserted in the EXC_FLUSH cycle -> all outputs 0 on the next cycle; after release, state is RUN.
REQ-029 With PIPE_CTRL_PERF_CNT_EN defined: counter preloaded to FFFFFFFE, then 3 stalled cycles -> stall_cycles reads 00000001.
